// File: rtl/pc_redirect_ctrl_if.sv
// pc_redirect_ctrl_if: bundle between the fetch redirect controller and its
// surroundings (decode/execute requesters and the PC register write port).
//   master : controller side (consumes requests, drives PC write port/status)
//   slave  : environment side (drives requests and pcIn, observes outputs)
// Signals:
//   pcIn               current PC value
//   stall              fetch stall, PC must not advance
//   brValid/brTarget   execute-stage branch redirect
//   jmpValid/jmpTarget decode-stage jump redirect
//   trapReq            trap request (only with PC_CTRL_TRAP_EN)
//   haltReq            halt request
//   pcAddrOut          PC write-port address
//   pcWrEnable         PC write enable
//   flush              kill wrong-path instructions
//   halted             core parked in HALT
// Optional feature macro: PC_CTRL_TRAP_EN
interface pc_redirect_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] pcIn;
  logic                  stall;
  logic                  brValid;
  logic [ADDR_WIDTH-1:0] brTarget;
  logic                  jmpValid;
  logic [ADDR_WIDTH-1:0] jmpTarget;
`ifdef PC_CTRL_TRAP_EN
  logic                  trapReq;
`endif
  logic                  haltReq;
  logic [ADDR_WIDTH-1:0] pcAddrOut;
  logic                  pcWrEnable;
  logic                  flush;
  logic                  halted;

  modport master (
`ifdef PC_CTRL_TRAP_EN
    input  trapReq,
`endif
    input  pcIn, stall, brValid, brTarget, jmpValid, jmpTarget, haltReq,
    output pcAddrOut, pcWrEnable, flush, halted
  );

  modport slave (
`ifdef PC_CTRL_TRAP_EN
    output trapReq,
`endif
    output pcIn, stall, brValid, brTarget, jmpValid, jmpTarget, haltReq,
    input  pcAddrOut, pcWrEnable, flush, halted
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: fetch-side PC sequencer. Arbitrates branch/jump (and
// optionally trap) redirects onto the PC write port, holds the PC during
// stalls, flushes wrong-path instructions after a redirect and parks the
// core on a halt request.
// Ports:
//   clk  clock
//   rst  synchronous active-low reset
//   bus  pc_redirect_ctrl_if.master (requests in, PC write port/status out)
// Parameters: ADDR_WIDTH, RESET_VECTOR, TRAP_VECTOR, FLUSH_CYCLES (1..15)
// Optional feature macro: PC_CTRL_TRAP_EN (adds trapReq and trap redirects;
// without it HALT is left only through reset).
module pc_redirect_ctrl #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR  = ADDR_WIDTH'(32'h100),
  parameter int                    FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  pc_redirect_ctrl_if.master  bus
);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HALT} state_t;

  // Priority codes: larger wins; 0 means no request.
  localparam logic [1:0] PRIO_NONE = 2'd0;
  localparam logic [1:0] PRIO_JMP  = 2'd1;
  localparam logic [1:0] PRIO_BR   = 2'd2;
  localparam logic [1:0] PRIO_TRAP = 2'd3;
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t                state, stateNxt;
  logic [3:0]            cnt, cntNxt;
  logic [1:0]            pendPrio, pendPrioNxt;
  logic [ADDR_WIDTH-1:0] pendTarget, pendTargetNxt;

  logic                  trapIn;
  logic [1:0]            newPrio, winPrio;
  logic [ADDR_WIDTH-1:0] newTarget, winTarget;
  logic                  wrEn, flushO;
  logic [ADDR_WIDTH-1:0] addrO;

  function automatic logic [1:0] reqPrio(input logic trap, input logic br, input logic jmp);
    if (trap)     return PRIO_TRAP;
    else if (br)  return PRIO_BR;
    else if (jmp) return PRIO_JMP;
    else          return PRIO_NONE;
  endfunction

  always_comb begin
    trapIn = 1'b0;
`ifdef PC_CTRL_TRAP_EN
    trapIn = bus.trapReq;
`endif
    newPrio = reqPrio(trapIn, bus.brValid, bus.jmpValid);
    case (newPrio)
      PRIO_TRAP: newTarget = TRAP_VECTOR;
      PRIO_BR:   newTarget = bus.brTarget;
      default:   newTarget = bus.jmpTarget;
    endcase

    // A fresh request of equal or higher priority displaces the pending one.
    if (newPrio != PRIO_NONE && newPrio >= pendPrio) begin
      winPrio   = newPrio;
      winTarget = newTarget;
    end else begin
      winPrio   = pendPrio;
      winTarget = pendTarget;
    end

    stateNxt      = state;
    cntNxt        = cnt;
    pendPrioNxt   = pendPrio;
    pendTargetNxt = pendTarget;
    wrEn          = 1'b0;
    addrO         = bus.pcIn;
    flushO        = 1'b0;

    case (state)
      S_RUN: begin
        if (bus.stall) begin
          wrEn          = 1'b1;
          pendPrioNxt   = winPrio;
          pendTargetNxt = winTarget;
        end else if (winPrio != PRIO_NONE) begin
          wrEn        = 1'b1;
          addrO       = winTarget;
          flushO      = 1'b1;
          pendPrioNxt = PRIO_NONE;
          if (FLUSH_CYCLES > 1) begin
            stateNxt = S_FLUSH;
            cntNxt   = FLUSH_LOAD;
          end
        end else if (bus.haltReq) begin
          wrEn     = 1'b1;
          stateNxt = S_HALT;
        end
      end

      S_FLUSH: begin
        // Branch/jump/halt here are wrong-path; only a trap survives.
        wrEn   = 1'b1;
        flushO = 1'b1;
        if (trapIn) begin
          pendPrioNxt   = PRIO_TRAP;
          pendTargetNxt = TRAP_VECTOR;
        end
        if (cnt <= 4'd1) begin
          stateNxt = S_RUN;
          cntNxt   = '0;
        end else begin
          cntNxt = cnt - 4'd1;
        end
      end

      S_HALT: begin
        wrEn = 1'b1;
`ifdef PC_CTRL_TRAP_EN
        if (trapIn || pendPrio == PRIO_TRAP) begin
          if (bus.stall) begin
            pendPrioNxt   = PRIO_TRAP;
            pendTargetNxt = TRAP_VECTOR;
          end else begin
            addrO       = TRAP_VECTOR;
            flushO      = 1'b1;
            pendPrioNxt = PRIO_NONE;
            if (FLUSH_CYCLES > 1) begin
              stateNxt = S_FLUSH;
              cntNxt   = FLUSH_LOAD;
            end else begin
              stateNxt = S_RUN;
            end
          end
        end
`endif
      end

      default: stateNxt = S_RUN;
    endcase

    // Reset forces the PC write port to the reset vector.
    if (!rst) begin
      wrEn   = 1'b0;
      addrO  = RESET_VECTOR;
      flushO = 1'b0;
    end
  end

  assign bus.pcWrEnable = wrEn;
  assign bus.pcAddrOut  = addrO;
  assign bus.flush      = flushO;
  assign bus.halted     = (state == S_HALT) && rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_RUN;
      cnt      <= '0;
      pendPrio <= PRIO_NONE;
    end else begin
      state    <= stateNxt;
      cnt      <= cntNxt;
      pendPrio <= pendPrioNxt;
    end
  end

  always_ff @(posedge clk) begin
    pendTarget <= pendTargetNxt;
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl (FLUSH_CYCLES=2, RESET_VECTOR=0,
// TRAP_VECTOR=0x100). Inputs change 1ns after posedge; outputs are checked
// on the negedge of the same cycle.
module tb_pc_redirect_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   nCmp = 0;
  int   nBad = 0;

  pc_redirect_ctrl_if #(.ADDR_WIDTH(32)) bus ();

  pc_redirect_ctrl #(
    .ADDR_WIDTH(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .FLUSH_CYCLES(2)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    bus.stall = 1'b0; bus.brValid = 1'b0; bus.jmpValid = 1'b0; bus.haltReq = 1'b0;
`ifdef PC_CTRL_TRAP_EN
    bus.trapReq = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b0; idleInputs(); bus.pcIn = 32'h44; bus.brTarget = 32'h0; bus.jmpTarget = 32'h0;
    bus.brValid = 1'b1; bus.brTarget = 32'h55;
    nextCycle(); nextCycle();
    @(negedge clk);
    nCmp++; if (bus.pcWrEnable !== 1'b0) begin nBad++; $display("FAIL rst_wr got %b want 0", bus.pcWrEnable); end
    nCmp++; if (bus.pcAddrOut !== 32'h0) begin nBad++; $display("FAIL rst_addr got %h want 0", bus.pcAddrOut); end
    nCmp++; if (bus.flush !== 1'b0) begin nBad++; $display("FAIL rst_flush got %b want 0", bus.flush); end
    nCmp++; if (bus.halted !== 1'b0) begin nBad++; $display("FAIL rst_halted got %b want 0", bus.halted); end
    nextCycle();
    idleInputs();
    rst = 1'b1;
  endtask

  task automatic test_run();
    for (int i = 0; i < 3; i++) begin
      bus.pcIn = 32'(i * 4);
      @(negedge clk);
      nCmp++; if (bus.pcWrEnable !== 1'b0) begin nBad++; $display("FAIL run_wr[%0d] got %b want 0", i, bus.pcWrEnable); end
      nCmp++; if (bus.flush !== 1'b0) begin nBad++; $display("FAIL run_flush[%0d] got %b want 0", i, bus.flush); end
      nCmp++; if (bus.halted !== 1'b0) begin nBad++; $display("FAIL run_halted[%0d] got %b want 0", i, bus.halted); end
      nCmp++; if (bus.pcAddrOut !== 32'(i * 4)) begin nBad++; $display("FAIL run_addr[%0d] got %h want %h", i, bus.pcAddrOut, i * 4); end
      nextCycle();
    end
  endtask

  task automatic test_priority();
    bus.pcIn = 32'hC;
    bus.brValid = 1'b1; bus.brTarget = 32'h40; bus.jmpValid = 1'b1; bus.jmpTarget = 32'h80;
    @(negedge clk);
    nCmp++; if (bus.pcAddrOut !== 32'h40) begin nBad++; $display("FAIL prio_addr got %h want 40", bus.pcAddrOut); end
    nCmp++; if (bus.pcWrEnable !== 1'b1) begin nBad++; $display("FAIL prio_wr got %b want 1", bus.pcWrEnable); end
    nCmp++; if (bus.flush !== 1'b1) begin nBad++; $display("FAIL prio_flush0 got %b want 1", bus.flush); end
    nextCycle();
    // jump during FLUSH must be ignored
    bus.brValid = 1'b0; bus.pcIn = 32'h40;
    @(negedge clk);
    nCmp++; if (bus.flush !== 1'b1) begin nBad++; $display("FAIL prio_flush1 got %b want 1", bus.flush); end
    nCmp++; if (bus.pcAddrOut !== 32'h40) begin nBad++; $display("FAIL prio_hold got %h want 40", bus.pcAddrOut); end
    nCmp++; if (bus.pcWrEnable !== 1'b1) begin nBad++; $display("FAIL prio_holdwr got %b want 1", bus.pcWrEnable); end
    nextCycle();
    bus.jmpValid = 1'b0; bus.pcIn = 32'h44;
    @(negedge clk);
    nCmp++; if (bus.flush !== 1'b0) begin nBad++; $display("FAIL prio_flush2 got %b want 0", bus.flush); end
    nCmp++; if (bus.pcWrEnable !== 1'b0) begin nBad++; $display("FAIL prio_jmp_ignored got %b want 0", bus.pcWrEnable); end
    nextCycle();
  endtask

  task automatic test_stall();
    bus.pcIn = 32'h48; bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.jmpValid = (i == 0); bus.jmpTarget = 32'h20;
      bus.brValid  = (i == 1); bus.brTarget  = 32'h30;
      @(negedge clk);
      nCmp++; if (bus.pcWrEnable !== 1'b1) begin nBad++; $display("FAIL stall_wr[%0d] got %b want 1", i, bus.pcWrEnable); end
      nCmp++; if (bus.pcAddrOut !== 32'h48) begin nBad++; $display("FAIL stall_addr[%0d] got %h want 48", i, bus.pcAddrOut); end
      nCmp++; if (bus.flush !== 1'b0) begin nBad++; $display("FAIL stall_flush[%0d] got %b want 0", i, bus.flush); end
      nextCycle();
    end
    idleInputs();
    @(negedge clk);
    nCmp++; if (bus.pcAddrOut !== 32'h30) begin nBad++; $display("FAIL stall_apply got %h want 30", bus.pcAddrOut); end
    nCmp++; if (bus.flush !== 1'b1) begin nBad++; $display("FAIL stall_flush got %b want 1", bus.flush); end
    nextCycle();
    bus.pcIn = 32'h30;
    nextCycle();
    bus.pcIn = 32'h34;
    @(negedge clk);
    nCmp++; if (bus.pcWrEnable !== 1'b0) begin nBad++; $display("FAIL stall_resume got %b want 0", bus.pcWrEnable); end
    nextCycle();
  endtask

  task automatic test_halt_vs_redirect();
    bus.pcIn = 32'h38; bus.haltReq = 1'b1; bus.brValid = 1'b1; bus.brTarget = 32'h70;
    @(negedge clk);
    nCmp++; if (bus.pcAddrOut !== 32'h70) begin nBad++; $display("FAIL hvr_addr got %h want 70", bus.pcAddrOut); end
    nextCycle();
    idleInputs(); bus.pcIn = 32'h70;
    nextCycle();
    bus.pcIn = 32'h74;
    @(negedge clk);
    nCmp++; if (bus.halted !== 1'b0) begin nBad++; $display("FAIL hvr_halt_dropped got %b want 0", bus.halted); end
    nCmp++; if (bus.pcWrEnable !== 1'b0) begin nBad++; $display("FAIL hvr_wr got %b want 0", bus.pcWrEnable); end
    nextCycle();
  endtask

  task automatic test_halt();
    bus.pcIn = 32'h50; bus.haltReq = 1'b1;
    @(negedge clk);
    nCmp++; if (bus.pcWrEnable !== 1'b1) begin nBad++; $display("FAIL halt_wr0 got %b want 1", bus.pcWrEnable); end
    nCmp++; if (bus.halted !== 1'b0) begin nBad++; $display("FAIL halt_early got %b want 0", bus.halted); end
    nextCycle();
    bus.haltReq = 1'b0; bus.brValid = 1'b1; bus.brTarget = 32'h90;
    @(negedge clk);
    nCmp++; if (bus.halted !== 1'b1) begin nBad++; $display("FAIL halt_on got %b want 1", bus.halted); end
    nCmp++; if (bus.pcAddrOut !== 32'h50) begin nBad++; $display("FAIL halt_br_ignored got %h want 50", bus.pcAddrOut); end
    nCmp++; if (bus.flush !== 1'b0) begin nBad++; $display("FAIL halt_flush got %b want 0", bus.flush); end
    nextCycle();
    bus.brValid = 1'b0;
`ifdef PC_CTRL_TRAP_EN
    bus.trapReq = 1'b1;
    @(negedge clk);
    nCmp++; if (bus.pcAddrOut !== 32'h100) begin nBad++; $display("FAIL trap_addr got %h want 100", bus.pcAddrOut); end
    nCmp++; if (bus.flush !== 1'b1) begin nBad++; $display("FAIL trap_flush got %b want 1", bus.flush); end
    nextCycle();
    bus.trapReq = 1'b0; bus.pcIn = 32'h100;
    @(negedge clk);
    nCmp++; if (bus.halted !== 1'b0) begin nBad++; $display("FAIL trap_unhalt got %b want 0", bus.halted); end
    nextCycle();
`else
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nCmp++; if (bus.halted !== 1'b1) begin nBad++; $display("FAIL halt_persist[%0d] got %b want 1", i, bus.halted); end
      nCmp++; if (bus.pcWrEnable !== 1'b1) begin nBad++; $display("FAIL halt_hold[%0d] got %b want 1", i, bus.pcWrEnable); end
      nextCycle();
    end
`endif
  endtask

  task automatic test_reset_mid_flush();
    rst = 1'b0;
    nextCycle();
    rst = 1'b1; bus.pcIn = 32'h8;
    @(negedge clk);
    nCmp++; if (bus.halted !== 1'b0) begin nBad++; $display("FAIL rmf_unhalt got %b want 0", bus.halted); end
    nextCycle();
    bus.brValid = 1'b1; bus.brTarget = 32'h60;
    @(negedge clk);
    nCmp++; if (bus.flush !== 1'b1) begin nBad++; $display("FAIL rmf_flush0 got %b want 1", bus.flush); end
    nextCycle();
    bus.brValid = 1'b0; bus.pcIn = 32'h60; rst = 1'b0;
    @(negedge clk);
    nCmp++; if (bus.flush !== 1'b0) begin nBad++; $display("FAIL rmf_flush_rst got %b want 0", bus.flush); end
    nCmp++; if (bus.pcAddrOut !== 32'h0) begin nBad++; $display("FAIL rmf_addr got %h want 0", bus.pcAddrOut); end
    nCmp++; if (bus.pcWrEnable !== 1'b0) begin nBad++; $display("FAIL rmf_wr got %b want 0", bus.pcWrEnable); end
    nextCycle();
    rst = 1'b1; bus.pcIn = 32'h0;
    @(negedge clk);
    nCmp++; if (bus.flush !== 1'b0) begin nBad++; $display("FAIL rmf_run_flush got %b want 0", bus.flush); end
    nCmp++; if (bus.pcWrEnable !== 1'b0) begin nBad++; $display("FAIL rmf_run_wr got %b want 0", bus.pcWrEnable); end
    nextCycle();
  endtask

  initial begin
    test_reset();
    test_run();
    test_priority();
    test_stall();
    test_halt_vs_redirect();
    test_halt();
    test_reset_mid_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Fetch-side controller that sequences the program counter. It drives the PC's external write port (`pcAddrOut` to its `addrIn`, `pcWrEnable` to its `wrEnable`) and arbitrates between branch, jump and (optionally) trap redirects. It also holds the PC during fetch stalls, flushes wrong-path instructions after a redirect, and parks the core on a halt request. It sits between the decode/execute stages and the PC register.

## Interface
- `ADDR_WIDTH`, 32, instruction address width; matches the PC path.
- `RESET_VECTOR`, 0, value driven on `pcAddrOut` while in reset.
- `TRAP_VECTOR`, 32'h100, trap target; used only with `PC_CTRL_TRAP_EN`.
- `FLUSH_CYCLES`, 2, number of cycles `flush` is asserted per redirect; legal range 1..15.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-low.
- `pcIn`  in  ADDR_WIDTH  current PC value (PC `addrOut`).
- `stall`  in  1  fetch stall; the PC must not advance.
- `brValid` / `brTarget`  in  1 / ADDR_WIDTH  execute-stage branch redirect.
- `jmpValid` / `jmpTarget`  in  1 / ADDR_WIDTH  decode-stage jump redirect.
- `trapReq`  in  1  trap request; port exists only with `PC_CTRL_TRAP_EN`.
- `haltReq`  in  1  halt request.
- `pcAddrOut`  out  ADDR_WIDTH  address for the PC write port.
- `pcWrEnable`  out  1  PC write enable.
- `flush`  out  1  kill in-flight fetched/decoded instructions.
- `halted`  out  1  core is parked in HALT.

## Operation
- **States:** RUN, FLUSH, HALT. Registers: state, 4-bit flush counter, pending valid/target.
- **Redirect priority:** trap > branch > jump. The pending redirect competes at its captured priority, and a new request of equal or higher priority overwrites it.
- **RUN, `stall`=0, redirect present (new or pending):**
  - Drive `pcWrEnable`=1, `pcAddrOut`=winning target, `flush`=1.
  - Clear pending.
  - Go to FLUSH with counter=FLUSH_CYCLES-1; if FLUSH_CYCLES=1, stay in RUN.
- **RUN, `stall`=1:**
  - Drive `pcWrEnable`=1, `pcAddrOut`=`pcIn` (hold).
  - Capture any redirect into pending; `flush`=0.
- **RUN, `stall`=0, no redirect, `haltReq`=1:** hold the PC as above and go to HALT.
- **RUN, `stall`=0, no redirect, no halt:** `pcWrEnable`=0, so the PC self-increments.
- **FLUSH:**
  - `flush`=1 and the PC is held (`pcWrEnable`=1, `pcAddrOut`=`pcIn`).
  - `brValid`, `jmpValid` and `haltReq` are ignored as wrong-path.
  - `trapReq` is captured into pending.
  - Counter decrements; go to RUN when it reaches 0.
- **HALT:**
  - `halted`=1 and the PC is held.
  - Branch, jump and halt requests are ignored.
  - Exit only by trap (see Configuration) or reset.
- **Simultaneous events:** a redirect beats `haltReq` in the same cycle, and the halt is dropped, so the requester must re-assert it. `stall` defers both redirect and halt.
- **`pcAddrOut` when `pcWrEnable`=0:** equals `pcIn`.

## Timing
- `pcWrEnable`, `pcAddrOut` and cycle-1 `flush` are combinational from state, pending and inputs, so the PC is updated at the same edge.
- **Redirect latency:** redirect presented in cycle N with `stall`=0 means the PC equals the target after edge N. `flush` is high for cycles N..N+FLUSH_CYCLES-1, and normal increment resumes in cycle N+FLUSH_CYCLES.
- **Stalled redirect:** applied in the first cycle with `stall`=0, with the same timing measured from that cycle.
- **During reset (`rst`=0):** outputs are forced to `pcWrEnable`=0, `pcAddrOut`=RESET_VECTOR, `flush`=0, `halted`=0.
- **State at the first edge with `rst`=0:** state=RUN, pending cleared, counter=0. Reset mid-FLUSH or mid-HALT abandons the operation at that edge.

## Configuration
- **`PC_CTRL_TRAP_EN` defined:**
  - `trapReq` port exists; a trap redirects to TRAP_VECTOR at top priority from any state.
  - From HALT, a trap goes to FLUSH with `halted`=0.
  - During FLUSH, a trap is captured and applied on return to RUN.
- **`PC_CTRL_TRAP_EN` undefined:** no `trapReq` port, no trap logic, and HALT is terminal until reset.

## Test plan
- Reset, release, no requests, `pcIn`=0,4,8 → `pcWrEnable`=0 every cycle, `flush`=0, `halted`=0.
- `brValid`=1 with `brTarget`=0x40 and `jmpValid`=1 with `jmpTarget`=0x80 in the same cycle → `pcAddrOut`=0x40, `pcWrEnable`=1; `flush` high for exactly 2 cycles; a `jmpValid` presented during FLUSH is ignored.
- `stall`=1 for 3 cycles with `jmpTarget`=0x20 in stall cycle 1 and `brTarget`=0x30 in stall cycle 2 → PC held at `pcIn`; on the first cycle with `stall`=0, `pcAddrOut`=0x30.
- `haltReq`=1 with no redirect → `halted`=1 from the next cycle and the PC is held; later `brValid` → no effect.
- With `PC_CTRL_TRAP_EN`, `trapReq` in HALT → `pcAddrOut`=0x100, `flush`=1, `halted` drops next cycle; without the macro, HALT persists until `rst`=0.
- `rst`=0 asserted in the middle of FLUSH → `flush`=0 and `pcAddrOut`=RESET_VECTOR while low; RUN after release.
